// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and defaults for the issue-stage interlock
package hazard_ctrl_pkg;

    // Which long-latency producer owns a pending scoreboard entry.
    typedef enum logic [1:0] {
        SB_NONE   = 2'd0,
        SB_LOAD   = 2'd1,
        SB_MULDIV = 2'd2
    } sb_src_e;

    // Pipeline control bundle driven toward IF/ID/EX.
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic bubble_ex;
        logic flush_if_id;
    } hazard_t;

    localparam int MULDIV_LAT_DEFAULT = 4;
    localparam int MAX_LOADS_DEFAULT  = 2;

    // One-hot register mask; x0 never maps to a bit so it can never be pending or cleared.
    function automatic logic [31:0] reg_onehot(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : (32'd1 << r);
    endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_timer.sv
// rtl/hazard_ctrl_muldiv_timer.sv - mul/div latency countdown with registered completion pulse
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           a mul/div issues this cycle
//   start_rd        destination of the issuing mul/div
//   busy            countdown running
//   count           cycles left until the result cycle (0 when idle)
//   done            one-cycle pulse: result written this cycle
//   done_rd         destination of the completing mul/div (0 when done is low)
module hazard_ctrl_muldiv_timer #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = $clog2(MULDIV_LAT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       start_rd,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             done,
    output logic [4:0]       done_rd
);

    logic [CNT_W-1:0] count_q;
    logic [4:0]       rd_q;
    logic             last_cycle;

    // count==1 means the result lands next cycle. A new issue may arrive in this same
    // cycle, so the completing rd is copied to done_rd before rd_q is overwritten.
    assign last_cycle = (count_q == CNT_W'(1));
    assign busy       = (count_q != '0);
    assign count      = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            rd_q    <= 5'd0;
            done    <= 1'b0;
            done_rd <= 5'd0;
        end else begin
            done    <= last_cycle;
            done_rd <= last_cycle ? rd_q : 5'd0;
            if (start) begin
                count_q <= CNT_W'(MULDIV_LAT - 1);
                rd_q    <= start_rd;
            end else if (busy) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID->EX interlock: long-latency scoreboard, stall/bubble/flush generation
//
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   id_valid/id_rs1/id_rs2/id_rd       instruction in ID and its registers
//   id_wen/id_is_load/id_is_muldiv     ID instruction class
//   load_done/load_done_rd             returning load (visible on load bypass this cycle)
//   ex_redirect                        EX mispredict, squashes ID
//   stall_if/stall_id/bubble_ex        interlock controls (combinational)
//   flush_if_id                        squash IF/ID (combinational)
//   muldiv_done/muldiv_rd              registered mul/div completion pulse
//   loads_inflight                     registered outstanding-load count
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT,
    parameter int MAX_LOADS  = MAX_LOADS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_wen,
    input  logic       id_is_load,
    input  logic       id_is_muldiv,
    input  logic       load_done,
    input  logic [4:0] load_done_rd,
    input  logic       ex_redirect,
    output logic       stall_if,
    output logic       stall_id,
    output logic       bubble_ex,
    output logic       flush_if_id,
    output logic       muldiv_done,
    output logic [4:0] muldiv_rd,
    output logic [2:0] loads_inflight
);

    localparam int CNT_W = $clog2(MULDIV_LAT);

    logic [31:0]      pend_q;
    sb_src_e          src_q [32];
    logic [2:0]       loads_q;

    logic             md_busy;
    logic [CNT_W-1:0] md_count;

    logic             ld_clr;
    logic [31:0]      clear_now;
    logic [31:0]      blocked;
    logic             raw, waw, struct_md, struct_ld;
    logic             hazard_hit;
    logic             issue;
    logic             sb_set;
    logic             ld_issue, ld_ret;
    hazard_t          haz;

    hazard_ctrl_muldiv_timer #(
        .MULDIV_LAT (MULDIV_LAT),
        .CNT_W      (CNT_W)
    ) u_muldiv_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (issue & id_is_muldiv),
        .start_rd (id_rd),
        .busy     (md_busy),
        .count    (md_count),
        .done     (muldiv_done),
        .done_rd  (muldiv_rd)
    );

    // A returning load only retires an entry a load owns; a mul/div entry with the same
    // rd must survive an unrelated load return.
    assign ld_clr    = load_done & pend_q[load_done_rd] & (src_q[load_done_rd] == SB_LOAD);
    assign clear_now = (ld_clr ? reg_onehot(load_done_rd) : 32'd0)
                     | (muldiv_done ? reg_onehot(muldiv_rd) : 32'd0);
    // Registers whose value is neither in the register file nor on a bypass this cycle.
    assign blocked   = pend_q & ~clear_now;

    assign raw       = ((id_rs1 != 5'd0) & blocked[id_rs1]) | ((id_rs2 != 5'd0) & blocked[id_rs2]);
    assign waw       = id_wen & (id_rd != 5'd0) & blocked[id_rd];
    // The mul/div unit accepts a new op once the current one is in its final cycle.
    assign struct_md = id_is_muldiv & md_busy & (md_count > CNT_W'(1));
    // A same-cycle load return frees a slot for the waiting load.
    assign struct_ld = id_is_load & (loads_q == 3'(MAX_LOADS)) & ~load_done;

    // Gated by reset so every output reads 0 while reset is held.
    assign hazard_hit = reset & id_valid & (raw | waw | struct_md | struct_ld);

    // Redirect wins over stall: the ID instruction is being squashed anyway.
    assign haz.flush_if_id = reset & ex_redirect;
    assign haz.stall_id    = hazard_hit & ~ex_redirect;
    assign haz.stall_if    = haz.stall_id;
    assign haz.bubble_ex   = hazard_hit | haz.flush_if_id;

    assign stall_if    = haz.stall_if;
    assign stall_id    = haz.stall_id;
    assign bubble_ex   = haz.bubble_ex;
    assign flush_if_id = haz.flush_if_id;

    assign issue    = id_valid & ~hazard_hit & ~ex_redirect;
    assign sb_set   = issue & id_wen & (id_rd != 5'd0) & (id_is_load | id_is_muldiv);
    assign ld_issue = issue & id_is_load;
    assign ld_ret   = load_done & (loads_q != 3'd0);

    assign loads_inflight = loads_q;

    // Scoreboard: clears first, then the set, so a same-cycle set of the same reg wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 32'd0;
            for (int r = 0; r < 32; r++) begin
                src_q[r] <= SB_NONE;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (clear_now[r]) begin
                    pend_q[r] <= 1'b0;
                    src_q[r]  <= SB_NONE;
                end
            end
            if (sb_set) begin
                pend_q[id_rd] <= 1'b1;
                src_q[id_rd]  <= id_is_load ? SB_LOAD : SB_MULDIV;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loads_q <= 3'd0;
        end else begin
            case ({ld_issue, ld_ret})
                2'b10:   loads_q <= loads_q + 3'd1;
                2'b01:   loads_q <= loads_q - 3'd1;
                default: loads_q <= loads_q;
            endcase
        end
    end

    // A load return with nothing outstanding points at a broken load/store unit.
    a_no_spurious_load_done : assert property (
        @(posedge clk) disable iff (!reset) !(load_done && loads_q == 3'd0)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed and random stimulus
module tb_hazard_ctrl;

    localparam int LAT  = 4;
    localparam int MAXL = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_wen, id_is_load, id_is_muldiv;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       load_done;
    logic [4:0] load_done_rd;
    logic       ex_redirect;
    logic       stall_if, stall_id, bubble_ex, flush_if_id;
    logic       muldiv_done;
    logic [4:0] muldiv_rd;
    logic [2:0] loads_inflight;

    hazard_ctrl #(.MULDIV_LAT(LAT), .MAX_LOADS(MAXL)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_wen         (id_wen),
        .id_is_load     (id_is_load),
        .id_is_muldiv   (id_is_muldiv),
        .load_done      (load_done),
        .load_done_rd   (load_done_rd),
        .ex_redirect    (ex_redirect),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .bubble_ex      (bubble_ex),
        .flush_if_id    (flush_if_id),
        .muldiv_done    (muldiv_done),
        .muldiv_rd      (muldiv_rd),
        .loads_inflight (loads_inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       stall_if;
        bit       stall_id;
        bit       bubble_ex;
        bit       flush;
        bit       md_done;
        int       md_rd;
        int       loads;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: per-register pending flag and owner (0 none, 1 load, 2 mul/div),
    // outstanding loads by destination, mul/div ops by destination and completion cycle.
    bit   m_pend[32];
    int   m_kind[32];
    int   m_loads[$];
    int   m_md_rd[$];
    int   m_md_due[$];
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic bit clr(input int r, input bit ldone, input int ldrd, input bit mdd, input int mdr);
        return (r != 0) && ((ldone && r == ldrd && m_pend[r] && m_kind[r] == 1) || (mdd && r == mdr));
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_pend[r] = 1'b0;
            m_kind[r] = 0;
        end
        m_loads.delete();
        m_md_rd.delete();
        m_md_due.delete();
    endfunction

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_wen = 0;
        id_is_load = 0; id_is_muldiv = 0; load_done = 0; load_done_rd = 0; ex_redirect = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall_if"}, stall_if, 0);
        check({tag, "_stall_id"}, stall_id, 0);
        check({tag, "_bubble_ex"}, bubble_ex, 0);
        check({tag, "_flush"}, flush_if_id, 0);
        check({tag, "_md_done"}, muldiv_done, 0);
        check({tag, "_md_rd"}, muldiv_rd, 0);
        check({tag, "_loads"}, loads_inflight, 0);
    endtask

    // One ID cycle: drive inputs, push the model's expectation, advance the model.
    task automatic step(input bit v, input int rs1, input int rs2, input int rd, input bit wen,
                        input bit ld, input bit md, input bit ldone, input int ldidx, input bit redir);
        exp_t e;
        int   ldrd, mdr;
        bit   mdd, blong, raw, waw, strct, stall, issue;
        @(posedge clk);
        #1;
        ldrd = ldone ? m_loads[ldidx] : int'($urandom_range(0, 31));
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd); id_wen = wen;
        id_is_load = ld; id_is_muldiv = md; load_done = ldone; load_done_rd = 5'(ldrd);
        ex_redirect = redir;

        mdd = 0; mdr = 0; blong = 0;
        foreach (m_md_due[i]) begin
            if (m_md_due[i] == cyc) begin mdd = 1; mdr = m_md_rd[i]; end
            if (m_md_due[i] - cyc > 1) blong = 1;
        end
        raw   = (rs1 != 0 && m_pend[rs1] && !clr(rs1, ldone, ldrd, mdd, mdr))
             || (rs2 != 0 && m_pend[rs2] && !clr(rs2, ldone, ldrd, mdd, mdr));
        waw   = wen && rd != 0 && m_pend[rd] && !clr(rd, ldone, ldrd, mdd, mdr);
        strct = (md && blong) || (ld && m_loads.size() == MAXL && !ldone);
        stall = v && (raw || waw || strct);
        issue = v && !stall && !redir;

        e.stall_id  = stall && !redir;
        e.stall_if  = e.stall_id;
        e.bubble_ex = stall || redir;
        e.flush     = redir;
        e.md_done   = mdd;
        e.md_rd     = mdr;
        e.loads     = m_loads.size();
        exp_q.push_back(e);

        for (int r = 1; r < 32; r++) begin
            if (clr(r, ldone, ldrd, mdd, mdr)) begin
                m_pend[r] = 0;
                m_kind[r] = 0;
            end
        end
        if (issue && wen && rd != 0 && (ld || md)) begin
            m_pend[rd] = 1;
            m_kind[rd] = ld ? 1 : 2;
        end
        if (ldone) m_loads.delete(ldidx);
        if (issue && ld) m_loads.push_back(rd);
        for (int i = m_md_due.size() - 1; i >= 0; i--) begin
            if (m_md_due[i] == cyc) begin
                m_md_due.delete(i);
                m_md_rd.delete(i);
            end
        end
        if (issue && md) begin
            m_md_rd.push_back(rd);
            m_md_due.push_back(cyc + LAT);
        end
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 0;
        idle_inputs();
        #1;
        check_all_zero(tag);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    // Monitor: every cycle that has an expectation, compare the DUT against it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mon_stall_if", stall_if, e.stall_if);
                check("mon_stall_id", stall_id, e.stall_id);
                check("mon_bubble_ex", bubble_ex, e.bubble_ex);
                check("mon_flush_if_id", flush_if_id, e.flush);
                check("mon_muldiv_done", muldiv_done, e.md_done);
                if (e.md_done) check("mon_muldiv_rd", muldiv_rd, e.md_rd);
                check("mon_loads_inflight", loads_inflight, e.loads);
            end
        end
    end

    initial begin
        int v, k, ldone, ldidx;
        reset = 0;
        idle_inputs();
        model_reset();
        #1;
        check_all_zero("reset0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1;

        // Load-use stall released by same-cycle load return.
        step(1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        step(1, 5, 0, 6, 1, 0, 0, 0, 0, 0);
        #1; check("t1_stall_id_a", stall_id, 1); check("t1_bubble_a", bubble_ex, 1);
        step(1, 5, 0, 6, 1, 0, 0, 0, 0, 0);
        #1; check("t1_stall_id_b", stall_id, 1);
        step(1, 5, 0, 6, 1, 0, 0, 1, 0, 0);
        #1; check("t1_release", stall_id, 0); check("t1_bubble_rel", bubble_ex, 0);
        idle();

        // Mul/div dependency waits LAT-1 cycles, issues on the done cycle.
        apply_reset("t2rst");
        step(1, 0, 0, 7, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < LAT - 1; i++) begin
            step(1, 0, 7, 8, 1, 0, 0, 0, 0, 0);
            #1; check("t2_stall", stall_id, 1);
        end
        step(1, 0, 7, 8, 1, 0, 0, 0, 0, 0);
        #1; check("t2_done", muldiv_done, 1); check("t2_rd", muldiv_rd, 7); check("t2_issue", stall_id, 0);
        idle();

        // Load slots full; a same-cycle return lets the third load issue.
        apply_reset("t3rst");
        step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 2, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 3, 1, 1, 0, 0, 0, 0);
        #1; check("t3_full_stall", stall_id, 1); check("t3_loads2", loads_inflight, 2);
        step(1, 0, 0, 3, 1, 1, 0, 1, 0, 0);
        #1; check("t3_issue", stall_id, 0);
        idle();
        #1; check("t3_loads_hold", loads_inflight, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Redirect overrides a RAW stall and leaves the scoreboard alone.
        apply_reset("t4rst");
        step(1, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        step(1, 5, 0, 6, 1, 0, 0, 0, 0, 1);
        #1; check("t4_flush", flush_if_id, 1); check("t4_stall_id", stall_id, 0);
        check("t4_stall_if", stall_if, 0); check("t4_bubble", bubble_ex, 1);
        step(1, 5, 0, 6, 1, 0, 0, 0, 0, 0);
        #1; check("t4_still_pend", stall_id, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Reset in the middle of a mul/div.
        apply_reset("t5rst");
        step(1, 0, 0, 9, 1, 0, 1, 0, 0, 0);
        idle();
        #2;
        reset = 0;
        id_valid = 1; id_rs1 = 9;
        #1;
        check_all_zero("t5_async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        step(1, 9, 0, 10, 1, 0, 0, 0, 0, 0);
        #1; check("t5_x9_clear", stall_id, 0);
        repeat (LAT + 1) idle();

        // x0 is never pending.
        apply_reset("t6rst");
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        #1; check("t6_x0_nostall", stall_id, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 800; n++) begin
            v     = ($urandom_range(0, 3) != 0);
            k     = $urandom_range(0, 3);
            ldone = (m_loads.size() > 0) && ($urandom_range(0, 2) == 0);
            ldidx = ldone ? $urandom_range(0, m_loads.size() - 1) : 0;
            step(v[0], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 ($urandom_range(0, 4) != 0), (k == 0), (k == 1), ldone[0], ldidx,
                 ($urandom_range(0, 15) == 0));
        end

        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
